// File: rtl/sram_access_arbiter_pkg.sv
// Shared types and defaults for the capture SRAM sequencer.
// Imported by the arbiter, the port interface and the top.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF     = 11;
  localparam int DATA_W_DEF     = 8;
  localparam int STROBE_CYC_DEF = 2;

  localparam int G_RD = 0;
  localparam int G_WR = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester handshakes plus the SRAM pin bundle.
// master = sequencer side, slave = requesters and SRAM.
interface sram_access_arbiter_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              busy;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_drive;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_active;
  logic              mem_rw;
  logic              mem_oe_n;

  modport master (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_done,
    input  rd_req,
    input  rd_addr,
    output rd_data,
    output rd_valid,
    output busy,
    output mem_addr,
    output mem_data_out,
    output mem_drive,
    input  mem_data_in,
    output mem_active,
    output mem_rw,
    output mem_oe_n
  );

  modport slave (
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_done,
    output rd_req,
    output rd_addr,
    input  rd_data,
    input  rd_valid,
    input  busy,
    input  mem_addr,
    input  mem_data_out,
    input  mem_drive,
    output mem_data_in,
    input  mem_active,
    input  mem_rw,
    input  mem_oe_n
  );

endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin between writer and reader.
// last remembers the op type of the previous grant.
module sram_rr_arbiter
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       arb_en,
  output logic [1:0] grant
);

  op_t last;

  always_comb begin
    grant = '0;
    unique case (1'b1)
      wr_req && rd_req: begin
        if (last == OP_READ) grant[G_WR] = 1'b1;
        else                 grant[G_RD] = 1'b1;
      end
      wr_req && !rd_req: grant[G_WR] = 1'b1;
      rd_req && !wr_req: grant[G_RD] = 1'b1;
      default: grant = '0;
    endcase
    if (!arb_en) grant = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= OP_READ;
    end else if (grant[G_WR]) begin
      last <= OP_WRITE;
    end else if (grant[G_RD]) begin
      last <= OP_READ;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Capture SRAM sequencer: setup/strobe/hold access cycles
// with round-robin sharing between writer and reader.
module sram_access_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STROBE_CYC = STROBE_CYC_DEF
) (
  input logic clk,
  input logic reset,
  sram_access_arbiter_if.master bus
);

  localparam int CW = $clog2(STROBE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(STROBE_CYC - 1);

  state_t        state;
  state_t        state_nxt;
  op_t           op;
  op_t           op_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    grant;
  logic          arb_en;
  logic          capture;

  assign arb_en = (state == IDLE);

  sram_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .wr_req (bus.wr_req),
    .rd_req (bus.rd_req),
    .arb_en (arb_en),
    .grant  (grant)
  );

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant[G_WR]) begin
          op_nxt    = OP_WRITE;
          state_nxt = SETUP;
        end else if (grant[G_RD]) begin
          op_nxt    = OP_READ;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        cnt_nxt   = '0;
        state_nxt = STROBE;
      end
      STROBE: begin
        if (cnt == CNT_LAST) begin
          state_nxt = HOLD;
          capture   = (op == OP_READ);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pin outputs are decoded from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      op               <= OP_READ;
      cnt              <= '0;
      bus.mem_addr     <= '0;
      bus.mem_data_out <= '0;
      bus.mem_drive    <= 1'b0;
      bus.mem_active   <= 1'b0;
      bus.mem_rw       <= 1'b1;
      bus.mem_oe_n     <= 1'b1;
      bus.wr_done      <= 1'b0;
      bus.rd_valid     <= 1'b0;
      bus.rd_data      <= '0;
      bus.busy         <= 1'b0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      cnt   <= cnt_nxt;
      if (grant[G_WR]) begin
        bus.mem_addr     <= bus.wr_addr;
        bus.mem_data_out <= bus.wr_data;
      end else if (grant[G_RD]) begin
        bus.mem_addr <= bus.rd_addr;
      end
      bus.mem_active <= (state_nxt != IDLE);
      bus.busy       <= (state_nxt != IDLE);
      bus.mem_drive  <= (state_nxt != IDLE) &&
                        (op_nxt == OP_WRITE);
      bus.mem_rw     <= !((state_nxt == STROBE) &&
                          (op_nxt == OP_WRITE));
      bus.mem_oe_n   <= !((op_nxt == OP_READ) &&
                          ((state_nxt == SETUP) ||
                           (state_nxt == STROBE)));
      bus.wr_done    <= (state_nxt == HOLD) &&
                        (op_nxt == OP_WRITE);
      bus.rd_valid   <= (state_nxt == HOLD) &&
                        (op_nxt == OP_READ);
      if (capture) bus.rd_data <= bus.mem_data_in;
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a
// behavioural SRAM model on the pin side.
module tb_sram_access_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sram_access_arbiter_if #(
    .ADDR_W (11),
    .DATA_W (8)
  ) bus ();

  sram_access_arbiter #(
    .ADDR_W     (11),
    .DATA_W     (8),
    .STROBE_CYC (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] sram [0:2047];

  always @(posedge clk) begin
    if (bus.mem_active && bus.mem_drive && !bus.mem_rw)
      sram[bus.mem_addr] = bus.mem_data_out;
  end

  assign bus.mem_data_in =
    bus.mem_oe_n ? 8'h00 : sram[bus.mem_addr];

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(bus.mem_drive && !bus.mem_oe_n))
      else begin
        viol++;
        $display("FAIL bus_conflict drive=1 oe_n=0 at %0t",
                 $time);
      end
      assert (!(!bus.mem_oe_n && !bus.mem_rw))
      else begin
        viol++;
        $display("FAIL oe_rw_overlap oe_n=0 rw=0 at %0t",
                 $time);
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // {active, drive, rw, oe_n, wr_done, rd_valid, busy}
  function automatic logic [6:0] flags();
    return {bus.mem_active, bus.mem_drive, bus.mem_rw,
            bus.mem_oe_n, bus.wr_done, bus.rd_valid,
            bus.busy};
  endfunction

  typedef struct {
    bit         wr;
    logic [10:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
  } vec_t;

  localparam int NV = 7;
  vec_t vec [NV];
  logic [6:0] exp_w [1:5];
  logic [6:0] exp_r [1:5];

  bit evq [$];
  int tq  [$];
  int idle_n;

  task automatic run_seq(input int nw, input int nr,
                         input int budget);
    int  wl;
    int  rl;
    bit  wd;
    bit  rd;
    int  c;
    evq.delete();
    tq.delete();
    idle_n = 0;
    wl = nw;
    rl = nr;
    bus.wr_req = (nw > 0);
    bus.rd_req = (nr > 0);
    c = 0;
    while (c < budget && (wl > 0 || rl > 0)) begin
      @(negedge clk);
      c++;
      wd = 1'b0;
      rd = 1'b0;
      if (!bus.busy) idle_n++;
      if (bus.wr_done) begin
        evq.push_back(1'b1);
        tq.push_back(c);
        wl--;
        bus.wr_req = 1'b0;
        wd = 1'b1;
      end
      if (bus.rd_valid) begin
        evq.push_back(1'b0);
        tq.push_back(c);
        rl--;
        bus.rd_req = 1'b0;
        rd = 1'b1;
      end
      if (!wd && !bus.wr_req && wl > 0) bus.wr_req = 1'b1;
      if (!rd && !bus.rd_req && rl > 0) bus.rd_req = 1'b1;
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    check("seq_timeout", wl + rl, 0);
  endtask

  initial begin
    int vcnt;
    int vt [$];

    for (int a = 0; a < 2048; a++) sram[a] = 8'h00;
    sram[7] = 8'hA5;

    exp_w[1] = 7'b1111001;
    exp_w[2] = 7'b1101001;
    exp_w[3] = 7'b1101001;
    exp_w[4] = 7'b1111101;
    exp_w[5] = 7'b0011000;
    exp_r[1] = 7'b1010001;
    exp_r[2] = 7'b1010001;
    exp_r[3] = 7'b1010001;
    exp_r[4] = 7'b1011011;
    exp_r[5] = 7'b0011000;

    vec[0] = '{1'b1, 11'h005, 8'h3C, 8'h11};
    vec[1] = '{1'b0, 11'h007, 8'h00, 8'hA5};
    vec[2] = '{1'b1, 11'h7FF, 8'hFF, 8'hA5};
    vec[3] = '{1'b0, 11'h7FF, 8'h00, 8'hFF};
    vec[4] = '{1'b1, 11'h000, 8'h5A, 8'hFF};
    vec[5] = '{1'b0, 11'h000, 8'h00, 8'h5A};
    vec[6] = '{1'b0, 11'h005, 8'h00, 8'h3C};

    reset       = 1'b1;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_flags", flags(), 7'b0011000);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_dout", bus.mem_data_out, 0);
    check("rst_rdata", bus.rd_data, 0);
    reset = 1'b0;

    // tie straight after reset: write first, read 5 later
    bus.wr_addr = 11'h020;
    bus.wr_data = 8'h11;
    bus.rd_addr = 11'h020;
    run_seq(1, 1, 40);
    check("tie_n", evq.size(), 2);
    if (evq.size() == 2) begin
      check("tie_first_w", evq[0], 1);
      check("tie_second_r", evq[1], 0);
      check("tie_t_done", tq[0], 4);
      check("tie_t_valid", tq[1], 9);
    end
    check("tie_idle", idle_n, 1);
    check("tie_rdata", bus.rd_data, 8'h11);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (vec[i].wr) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = vec[i].addr;
        bus.wr_data = vec[i].data;
      end else begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = vec[i].addr;
        bus.wr_data = 8'hEE;
      end
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        check($sformatf("v%0d_flags_c%0d", i, k), flags(),
              vec[i].wr ? exp_w[k] : exp_r[k]);
        if (k == 1) begin
          check($sformatf("v%0d_addr", i), bus.mem_addr,
                vec[i].addr);
          if (vec[i].wr)
            check($sformatf("v%0d_dout", i),
                  bus.mem_data_out, vec[i].data);
        end
        if (k == 4) begin
          bus.wr_req = 1'b0;
          bus.rd_req = 1'b0;
          if (!vec[i].wr)
            check($sformatf("v%0d_rd_hold", i),
                  bus.rd_data, vec[i].exp_rd);
        end
      end
      check($sformatf("v%0d_rd_after", i), bus.rd_data,
            vec[i].exp_rd);
      if (vec[i].wr)
        check($sformatf("v%0d_sram", i),
              sram[vec[i].addr], vec[i].data);
    end

    // continuous requests from both sides
    bus.wr_addr = 11'h030;
    bus.wr_data = 8'h42;
    bus.rd_addr = 11'h030;
    run_seq(3, 3, 80);
    check("cont_n", evq.size(), 6);
    if (evq.size() == 6) begin
      for (int j = 0; j < 6; j++) begin
        check($sformatf("cont_op%0d", j), evq[j],
              (j % 2 == 0) ? 1 : 0);
        check($sformatf("cont_t%0d", j), tq[j], 4 + 5 * j);
      end
    end
    check("cont_idle", idle_n, 5);
    check("cont_rdata", bus.rd_data, 8'h42);
    @(negedge clk);

    // reset in the middle of a write strobe
    bus.wr_req  = 1'b1;
    bus.wr_addr = 11'h010;
    bus.wr_data = 8'h77;
    repeat (2) @(negedge clk);
    check("rst_mid_rw", bus.mem_rw, 0);
    reset      = 1'b1;
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("rst_mid_flags", flags(), 7'b0011000);
    reset = 1'b0;
    vcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.wr_done) vcnt++;
    end
    check("rst_mid_no_done", vcnt, 0);
    bus.wr_addr = 11'h041;
    bus.wr_data = 8'h99;
    bus.rd_addr = 11'h041;
    run_seq(1, 1, 40);
    check("rst_tie_n", evq.size(), 2);
    if (evq.size() == 2) begin
      check("rst_tie_first_w", evq[0], 1);
      check("rst_tie_t_valid", tq[1], 9);
    end
    check("rst_tie_rdata", bus.rd_data, 8'h99);
    @(negedge clk);

    // sticky read request held one cycle past rd_valid
    bus.rd_addr = 11'h007;
    bus.rd_req  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.rd_valid) vt.push_back(c);
      if (c == 6) begin
        check("sticky_addr", bus.mem_addr, 11'h007);
        bus.rd_req = 1'b0;
      end
    end
    check("sticky_n", vt.size(), 2);
    if (vt.size() == 2) begin
      check("sticky_t0", vt[0], 4);
      check("sticky_t1", vt[1], 9);
    end
    check("sticky_rdata", bus.rd_data, 8'hA5);

    check("invariants", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Sequencer and arbiter for the 8-bit capture SRAM port. Two requesters share the single SRAM interface: the capture writer and the serial read-out engine. The block grants the port round-robin and generates a fixed setup/strobe/hold access sequence on address, data-drive, RW, output-enable and chip-select. The top level owns the tri-state buffer and drives the bidirectional data pins from `mem_data_out` when `mem_drive` is high.

## Interface
- `ADDR_W`, 11: SRAM address width.
- `DATA_W`, 8: data width.
- `STROBE_CYC`, 2: cycles the access strobe is held (≥1).
- `clk  in  1`: clock.
- `reset  in  1`: reset, synchronous, active-high.
- `wr_req  in  1`: write request, level; held until `wr_done`.
- `wr_addr  in  ADDR_W`: write address; sampled at grant.
- `wr_data  in  DATA_W`: write data; sampled at grant.
- `wr_done  out  1`: one-cycle pulse when the write completes.
- `rd_req  in  1`: read request, level; held until `rd_valid`.
- `rd_addr  in  ADDR_W`: read address; sampled at grant.
- `rd_data  out  DATA_W`: read result; stable from `rd_valid` until the next read completes.
- `rd_valid  out  1`: one-cycle pulse when `rd_data` is updated.
- `busy  out  1`: high in any state other than IDLE.
- `mem_addr  out  ADDR_W`: SRAM address.
- `mem_data_out  out  DATA_W`: data driven to the pins while `mem_drive` is high.
- `mem_drive  out  1`: controller drives the data bus.
- `mem_data_in  in  DATA_W`: data pins as seen from the SRAM.
- `mem_active  out  1`: chip select, active-high.
- `mem_rw  out  1`: 1 = read/idle, 0 = write strobe.
- `mem_oe_n  out  1`: 0 = SRAM drives the data bus.

## Operation
- FSM states: IDLE → SETUP → STROBE (STROBE_CYC cycles) → HOLD → IDLE. IDLE is always occupied for at least one cycle between accesses; this guarantees bus turnaround.
- **IDLE:** arbitrate when `wr_req` or `rd_req` is high.
  - Latch the op, the address and (for writes) the data, then go to SETUP.
  - Round-robin uses a `last` flag that records the op type of the last grant.
  - On simultaneous requests, the op not equal to `last` wins.
  - `last` resets to READ, so a write wins the first tie.
  - A single requester always wins, regardless of `last`.
- **Write sequence:**
  - SETUP: `mem_active`=1, `mem_drive`=1, `mem_addr`/`mem_data_out` valid, `mem_rw`=1.
  - STROBE: `mem_rw`=0.
  - HOLD: `mem_rw`=1, data still driven, `wr_done`=1.
- **Read sequence:**
  - SETUP: `mem_active`=1, `mem_oe_n`=0, `mem_rw`=1.
  - STROBE: waits; on the edge leaving the last STROBE cycle, `mem_data_in` is registered into `rd_data`.
  - HOLD: `mem_oe_n`=1, `rd_valid`=1.
- Both requesters must drop `req` at the edge where they observe done/valid. If `req` is still high in IDLE, it is treated as a new request.
- Invariant: `mem_drive` and `!mem_oe_n` are never both high. `mem_oe_n`=0 and `mem_rw`=0 never coincide.
- Addresses pass through unchanged; there is no wrap or increment. Sequencing addresses is the requesters' job.
- **Reset (including mid-access):** at the reset edge the FSM returns to IDLE and `last` becomes READ. No done/valid pulse is produced for the aborted access.

## Timing
- **Reset values:** `mem_addr`=0, `mem_data_out`=0, `mem_drive`=0, `mem_active`=0, `mem_rw`=1, `mem_oe_n`=1, `wr_done`=0, `rd_valid`=0, `rd_data`=0, `busy`=0.
- All outputs are registered.
- **Latency:** request high in IDLE at cycle T gives SETUP at T+1, STROBE at T+2 .. T+1+STROBE_CYC, and HOLD (done/valid) at T+2+STROBE_CYC.
- **Throughput:** one access per STROBE_CYC+3 cycles under continuous requests (with STROBE_CYC=2: one access per 5 cycles).
- **SRAM read:** `mem_data_in` must be valid by the last STROBE cycle, i.e. STROBE_CYC+1 cycles after address/OE are asserted.

## Structure
- Package `sram_ctrl_pkg`:
  - state enum `{IDLE, SETUP, STROBE, HOLD}`;
  - op enum `{OP_READ, OP_WRITE}`;
  - default width and timing constants.
- Sub-module `sram_rr_arbiter`: two-way round-robin with a registered `last` flag. Inputs are `wr_req`, `rd_req` and an `arb_en` strobe asserted in IDLE. Outputs are a one-hot grant.
- The top module contains the FSM, the strobe counter (width `$clog2(STROBE_CYC+1)`), and the address/data/op latches.

## Test plan
- **Single write:** `wr_req`, addr 0x005, data 0x3C, STROBE_CYC=2.
  - SETUP at T+1; `mem_rw`=0 at T+2..T+3; `wr_done` at T+4.
  - `mem_drive`=1 at T+1..T+4; SRAM model holds 0x3C at 0x005.
- **Single read:** model holds 0xA5 at 0x007.
  - `mem_oe_n`=0 at T+1..T+3; `rd_valid` at T+4 with `rd_data`=0xA5.
  - `rd_data` is held at 0xA5 afterwards.
- **Tie after reset:** `wr_req` and `rd_req` raised in the same cycle; write is granted first, then read.
  - `rd_valid` arrives 5 cycles after `wr_done`, with one IDLE cycle between the accesses.
- **Continuous requests:** both requesters hold `req` for 6 accesses.
  - Grant order is W,R,W,R,W,R; there is never a cycle with `mem_drive`=1 and `mem_oe_n`=0 (assertion).
- **Reset in STROBE of a write:** next cycle `mem_rw`=1, `mem_drive`=0, `mem_active`=0, `busy`=0; no `wr_done`.
  - After reset, a simultaneous tie grants write first.
- **Sticky request:** `rd_req` is held one cycle past `rd_valid`; a second read is issued to the same address.
  - `rd_valid` pulses again 5 cycles later.
